conv2d_stream: RTL and testbench

CONV2D_STREAM -- requirements
Module: conv2d_stream

---
 rtl/conv2d_stream_pkg.sv | 22 ++
 rtl/conv2d_stream_line.sv | 28 ++
 rtl/conv2d_stream.sv | 164 ++++++++++++++++
 tb/tb_conv2d_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_stream_pkg.sv
// Shared constants and helpers for the streaming 3x3 convolution: reset kernel,
// accumulator sizing and output saturation bounds.
package conv2d_stream_pkg;

  localparam int TAPS = 9;

  // Raster-order reset kernel: a Laplacian-style edge detector.
  localparam int RESET_KERNEL [TAPS] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};

  function automatic int acc_width(input int pixel_nb, input int kernel_nb);
    return pixel_nb + kernel_nb + 5;
  endfunction

  function automatic longint sat_max(input int out_nb);
    return (longint'(1) <<< (out_nb - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_nb);
    return -(longint'(1) <<< (out_nb - 1));
  endfunction

endpackage

// File: rtl/conv2d_stream_line.sv
// One image line of pixel storage, addressed by column; the read returns the
// value written one line earlier while the same beat overwrites it.
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming valid-region 3x3 convolution: two line buffers feed a window,
// then a product stage and a sum/shift/saturate/relu output stage.
module conv2d_stream
  import conv2d_stream_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int PIXEL_NB           = 8,
  parameter int KERNEL_NB          = 8,
  parameter int IMG_WIDTH          = 640,
  parameter int SHIFT              = 0,
  parameter int OUT_NB             = 16
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  input  logic                            k_we,
  input  logic [3:0]                      k_addr,
  input  logic [KERNEL_NB-1:0]            k_data,
  input  logic                            relu_en,
  output logic                            frame_err
);

  localparam int ACC_W  = acc_width(PIXEL_NB, KERNEL_NB);
  localparam int PROD_W = PIXEL_NB + KERNEL_NB + 1;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam longint MAX_V = sat_max(OUT_NB);
  localparam longint MIN_V = sat_min(OUT_NB);

  logic                        ready_ok, en, accept, at_end, frame_ok, frame_start;
  logic [CW-1:0]               col;
  logic [1:0]                  row;
  logic [PIXEL_NB-1:0]         pix, up1, up2;
  logic [PIXEL_NB-1:0]         win [TAPS];
  logic                        win_vld, win_last, prod_vld, prod_last;
  logic signed [KERNEL_NB-1:0] shadow [TAPS];
  logic signed [KERNEL_NB-1:0] active [TAPS];
  logic signed [PROD_W-1:0]    prod_d [TAPS];
  logic signed [PROD_W-1:0]    prod_q [TAPS];
  logic signed [ACC_W-1:0]     sum, shifted;
  longint                      wide;
  logic signed [OUT_NB-1:0]    res;
  logic [C_AXIS_TDATA_WIDTH-1:0] out_word;
  logic                        unused_tdata;

  assign en              = ~m00_axis_tvalid | m00_axis_tready;
  assign s00_axis_tready = en & ready_ok;
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign pix             = s00_axis_tdata[PIXEL_NB-1:0];
  assign at_end          = (col == LAST_COL);
  assign frame_ok        = at_end && (row == 2'd2);
  assign frame_start     = accept && (row == 2'd0) && (col == '0);
  assign m00_axis_tstrb  = '1;
  assign unused_tdata    = ^s00_axis_tdata;

  line_buffer #(.WIDTH(PIXEL_NB), .DEPTH(IMG_WIDTH)) u_line0 (
    .clk(s00_axis_aclk), .rst_n(s00_axis_aresetn), .en(accept),
    .addr(col), .wdata(pix), .rdata(up1)
  );

  line_buffer #(.WIDTH(PIXEL_NB), .DEPTH(IMG_WIDTH)) u_line1 (
    .clk(s00_axis_aclk), .rst_n(s00_axis_aresetn), .en(accept),
    .addr(col), .wdata(up1), .rdata(up2)
  );

  // A tlast always restarts the raster, even when it arrives in the wrong place.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      ready_ok  <= 1'b0;
      row       <= 2'd0;
      col       <= '0;
      frame_err <= 1'b0;
    end else begin
      ready_ok  <= 1'b1;
      frame_err <= accept & s00_axis_tlast & ~frame_ok;
      if (accept) begin
        if (s00_axis_tlast) begin
          row <= 2'd0;
          col <= '0;
        end else if (at_end) begin
          col <= '0;
          if (row != 2'd2) row <= row + 2'd1;
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // The frame-start copy forwards a same-cycle write so it is not lost.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= KERNEL_NB'(RESET_KERNEL[i]);
        active[i] <= KERNEL_NB'(RESET_KERNEL[i]);
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (k_we && k_addr == 4'(i)) shadow[i] <= k_data;
        if (frame_start) active[i] <= (k_we && k_addr == 4'(i)) ? k_data : shadow[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = $signed({{(PROD_W-PIXEL_NB){1'b0}}, win[i]}) *
                  $signed({{(PROD_W-KERNEL_NB){active[i][KERNEL_NB-1]}}, active[i]});
    end
    sum = '0;
    for (int i = 0; i < TAPS; i++) sum = sum + ACC_W'(prod_q[i]);
    shifted = sum >>> SHIFT;
    wide    = longint'(shifted);
    if (wide > MAX_V)      res = OUT_NB'(MAX_V);
    else if (wide < MIN_V) res = OUT_NB'(MIN_V);
    else                   res = OUT_NB'(wide);
    if (relu_en && res[OUT_NB-1]) res = '0;
    out_word = C_AXIS_TDATA_WIDTH'(res);
  end

  // Every stage, window included, freezes together while the output is stalled.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int i = 0; i < TAPS; i++) begin
        win[i]    <= '0;
        prod_q[i] <= '0;
      end
      win_vld         <= 1'b0;
      win_last        <= 1'b0;
      prod_vld        <= 1'b0;
      prod_last       <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
    end else if (en) begin
      win_vld  <= accept && (row == 2'd2) && (col >= CW'(2));
      win_last <= accept && s00_axis_tlast && frame_ok;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[3*r]   <= win[3*r+1];
          win[3*r+1] <= win[3*r+2];
        end
        win[2] <= up2;
        win[5] <= up1;
        win[8] <= pix;
      end
      for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
      prod_vld        <= win_vld;
      prod_last       <= win_last;
      m00_axis_tvalid <= prod_vld;
      m00_axis_tlast  <= prod_vld & prod_last;
      if (prod_vld) m00_axis_tdata <= out_word;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream on a 4-pixel-wide image: reset kernel, kernel
// loads, saturation/relu, output stall, malformed frames and mid-frame reset.
`timescale 1ns/1ps
module tb_conv2d_stream;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        k_we = 1'b0;
  logic [3:0]  k_addr = '0;
  logic [7:0]  k_data = '0;
  logic        relu_en = 1'b0;
  logic        frame_err;

  int          checks = 0;
  int          passed = 0;
  int          err_pulses = 0;
  int          err_base;
  logic [31:0] res_q [$];
  logic        last_q [$];

  always #5 clk = ~clk;

  conv2d_stream #(.IMG_WIDTH(W)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready), .s00_axis_tlast(s_tlast),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
    .m00_axis_tlast(m_tlast), .k_we(k_we), .k_addr(k_addr),
    .k_data(k_data), .relu_en(relu_en), .frame_err(frame_err)
  );

  // Results are collected at the falling edge, ahead of the edge that transfers them.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      res_q.push_back(m_tdata);
      last_q.push_back(m_tlast);
    end
    if (frame_err) err_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] p, input logic last);
    bit rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    s_tdata = 32'(p);
    s_tvalid = 1'b1;
    s_tlast = last;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if (!rdy) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic writeKernel(input logic [3:0] addr, input logic [7:0] data);
    k_addr = addr;
    k_data = data;
    k_we = 1'b1;
    @(posedge clk);
    #1;
    k_we = 1'b0;
  endtask

  task automatic setKernel(input logic [7:0] centre, input logic [7:0] other);
    for (int i = 0; i < 9; i++) writeKernel(4'(i), (i == 4) ? centre : other);
  endtask

  // kind 0: flat value; kind 1: ramp 0..15. kw_idx >= 0 writes the kernel before that beat.
  task automatic sendFrame(input int kind, input int value, input int kw_idx,
                           input logic [3:0] kw_addr, input logic [7:0] kw_data);
    for (int i = 0; i < W * 4; i++) begin
      if (i == kw_idx) writeKernel(kw_addr, kw_data);
      applyStimulus((kind == 0) ? 8'(value) : 8'(i), i == W * 4 - 1);
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    checkOutput({tag, "_count"}, 32'(res_q.size()), 32'd4);
    if (res_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("%s_data%0d", tag, i), res_q[i], e[i]);
        checkOutput($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    res_q.delete();
    last_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
    checkOutput("rst_tdata", m_tdata, 32'd0);
    checkOutput("rst_tready", 32'(s_tready), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("tready_before_clk", 32'(s_tready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("tready_after_clk", 32'(s_tready), 32'd1);
    checkOutput("tstrb", 32'(m_tstrb), 32'hF);

    // Flat image under the reset kernel cancels to zero.
    sendFrame(0, 10, -1, 4'd0, 8'd0);
    drain();
    checkFrame("flat", 0, 0, 0, 0);

    // Identity kernel picks the window centre of the ramp.
    setKernel(8'd1, 8'd0);
    sendFrame(1, 0, -1, 4'd0, 8'd0);
    drain();
    checkFrame("ramp", 5, 6, 9, 10);

    // 9*255*127 saturates high; 9*255*-128 saturates low, or clamps to 0 with relu.
    setKernel(8'd127, 8'd127);
    sendFrame(0, 255, -1, 4'd0, 8'd0);
    drain();
    checkFrame("sat_pos", 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
    setKernel(8'h80, 8'h80);
    sendFrame(0, 255, -1, 4'd0, 8'd0);
    drain();
    checkFrame("sat_neg", 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000);
    relu_en = 1'b1;
    sendFrame(0, 255, -1, 4'd0, 8'd0);
    drain();
    checkFrame("relu", 0, 0, 0, 0);
    relu_en = 1'b0;

    // Output stall while the second result is pending.
    setKernel(8'd1, 8'd0);
    fork
      sendFrame(1, 0, -1, 4'd0, 8'd0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_tvalid && n < 200);
        checkOutput("stall_first_seen", 32'(m_tvalid), 32'd1);
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput($sformatf("stall_tvalid%0d", c), 32'(m_tvalid), 32'd1);
          checkOutput($sformatf("stall_tdata%0d", c), m_tdata, 32'd6);
          checkOutput($sformatf("stall_tlast%0d", c), 32'(m_tlast), 32'd0);
          checkOutput($sformatf("stall_s_tready%0d", c), 32'(s_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    checkFrame("bp", 5, 6, 9, 10);

    // Premature tlast at row 1, col 2.
    err_base = err_pulses;
    for (int i = 0; i < 7; i++) applyStimulus(8'(i), i == 6);
    drain();
    checkOutput("err_pulse", 32'(err_pulses - err_base), 32'd1);
    checkOutput("err_no_output", 32'(res_q.size()), 32'd0);
    sendFrame(1, 0, -1, 4'd0, 8'd0);
    drain();
    checkFrame("after_err", 5, 6, 9, 10);
    checkOutput("err_single", 32'(err_pulses - err_base), 32'd1);

    // Mid-frame centre write takes effect only on the next frame; address 12 is ignored.
    sendFrame(1, 0, 5, 4'd4, 8'd2);
    drain();
    checkFrame("kw_cur", 5, 6, 9, 10);
    writeKernel(4'd12, 8'd50);
    sendFrame(1, 0, -1, 4'd0, 8'd0);
    drain();
    checkFrame("kw_next", 10, 12, 18, 20);

    // Reset with a result held at the output, then a clean frame on the reset kernel.
    m_tready = 1'b0;
    for (int i = 0; i < 11; i++) applyStimulus(8'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
    checkOutput("pre_rst_tdata", m_tdata, 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("mid_rst_tdata", m_tdata, 32'd0);
    checkOutput("mid_rst_tlast", 32'(m_tlast), 32'd0);
    checkOutput("mid_rst_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    res_q.delete();
    last_q.delete();
    sendFrame(1, 0, -1, 4'd0, 8'd0);
    drain();
    checkFrame("post_rst", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
